// File: rtl/lot_pkg.sv
// Shared types and constants for the parking-lot gate monitor.
// The sensor pair is always packed as ab = {outer, inner}, 1 = beam blocked.
package lot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENT_A,
        ENT_AB,
        ENT_B,
        EXT_B,
        EXT_AB,
        EXT_A,
        ERR
    } gate_state_t;

    localparam logic [1:0] AB_NONE = 2'b00;
    localparam logic [1:0] AB_A    = 2'b10;
    localparam logic [1:0] AB_B    = 2'b01;
    localparam logic [1:0] AB_BOTH = 2'b11;

endpackage : lot_pkg

// File: rtl/gate_sequence_fsm.sv
// Decodes the synchronised outer/inner beam sequence into completed entry and
// exit events. A car must break outer, both, inner, then clear (or the reverse)
// to count; aborts and back-outs return to IDLE silently, and impossible jumps
// park the machine in ERR until both beams clear.
// enter_set/exit_set are the combinational completion strobes: the owner of the
// car count uses them so its register updates on the same edge as the pulses.
module gate_sequence_fsm
    import lot_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ab,
    output logic       enter_set,
    output logic       exit_set,
    output logic       enter_pulse,
    output logic       exit_pulse,
    output logic       error
);

    gate_state_t state_q;
    gate_state_t state_d;
    logic        enter_pulse_q;
    logic        exit_pulse_q;

    // State and pulse registers; reset abandons any car in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            enter_pulse_q <= 1'b0;
            exit_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            enter_pulse_q <= enter_set;
            exit_pulse_q  <= exit_set;
        end
    end

    // Next-state decode; any beam pattern not listed for a state holds it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if      (ab == AB_A)    state_d = ENT_A;
                else if (ab == AB_B)    state_d = EXT_B;
                else if (ab == AB_BOTH) state_d = ERR;
            end
            ENT_A: begin
                if      (ab == AB_BOTH) state_d = ENT_AB;
                else if (ab == AB_NONE) state_d = IDLE;
                else if (ab == AB_B)    state_d = ERR;
            end
            ENT_AB: begin
                if      (ab == AB_B)    state_d = ENT_B;
                else if (ab == AB_A)    state_d = ENT_A;
                else if (ab == AB_NONE) state_d = ERR;
            end
            ENT_B: begin
                if      (ab == AB_NONE) state_d = IDLE;
                else if (ab == AB_BOTH) state_d = ENT_AB;
                else if (ab == AB_A)    state_d = ERR;
            end
            EXT_B: begin
                if      (ab == AB_BOTH) state_d = EXT_AB;
                else if (ab == AB_NONE) state_d = IDLE;
                else if (ab == AB_A)    state_d = ERR;
            end
            EXT_AB: begin
                if      (ab == AB_A)    state_d = EXT_A;
                else if (ab == AB_B)    state_d = EXT_B;
                else if (ab == AB_NONE) state_d = ERR;
            end
            EXT_A: begin
                if      (ab == AB_NONE) state_d = IDLE;
                else if (ab == AB_BOTH) state_d = EXT_AB;
                else if (ab == AB_B)    state_d = ERR;
            end
            ERR: begin
                if (ab == AB_NONE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion strobes and status outputs; the two strobes come from
    // different states so they can never be high together.
    always_comb begin
        enter_set   = (state_q == ENT_B) && (ab == AB_NONE);
        exit_set    = (state_q == EXT_A) && (ab == AB_NONE);
        enter_pulse = enter_pulse_q;
        exit_pulse  = exit_pulse_q;
        error       = (state_q == ERR);
    end

endmodule : gate_sequence_fsm

// File: rtl/lot_occupancy_tracker.sv
// Parking-lot gate monitor: synchronises the two raw photo-sensors, runs the
// gate sequence decoder and keeps a saturating count of cars in the lot.
// A raw sensor change before edge N reaches the decoder at edge N+2, where the
// event pulse and the count update are registered together.
module lot_occupancy_tracker
    import lot_pkg::*;
#(
    parameter  int MAX_CARS = 16,
    localparam int CW       = $clog2(MAX_CARS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sensor_a,
    input  logic          sensor_b,
    output logic [CW-1:0] count,
    output logic          occupied,
    output logic          full,
    output logic          enter_pulse,
    output logic          exit_pulse,
    output logic          error
);

    localparam logic [CW-1:0] CAP = CW'(MAX_CARS);

    logic [1:0]    ab_meta_q;
    logic [1:0]    ab_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          enter_set;
    logic          exit_set;

    // Two-flop synchroniser for both sensors, packed as {outer, inner}.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ab_meta_q <= AB_NONE;
            ab_q      <= AB_NONE;
        end else begin
            ab_meta_q <= {sensor_a, sensor_b};
            ab_q      <= ab_meta_q;
        end
    end

    gate_sequence_fsm u_fsm (
        .clk         (clk),
        .reset       (reset),
        .ab          (ab_q),
        .enter_set   (enter_set),
        .exit_set    (exit_set),
        .enter_pulse (enter_pulse),
        .exit_pulse  (exit_pulse),
        .error       (error)
    );

    // Saturating count: entries stop at capacity, exits stop at zero; the
    // events themselves are still reported even when the count cannot move.
    always_comb begin
        count_d = count_q;
        if (enter_set && (count_q != CAP)) begin
            count_d = count_q + CW'(1);
        end else if (exit_set && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    // Count register, updated on the same edge as the event pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Status flags decoded straight from the count register.
    always_comb begin
        count    = count_q;
        occupied = (count_q != '0);
        full     = (count_q == CAP);
    end

endmodule : lot_occupancy_tracker
